// File: rtl/muldiv_unit_if.sv
// Bus between the pipeline control and the iterative multiply/divide unit.
// The pipeline side (master) issues operations and MT writes. The unit side
// (slave) returns the handshake and the HI/LO contents.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] mt_data;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi, mtlo, mt_data,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, mt_data,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MIPS multiply/divide unit with HI/LO result registers.
// Every operation takes 32 RUN cycles plus one FIX cycle. Operands are
// converted to magnitudes at start, and the sign is restored in FIX.
module muldiv_unit (
    input logic          clk,
    input logic          rst,
    muldiv_unit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t      state;
    state_t      state_next;
    logic [4:0]  cnt;
    logic        is_div;
    logic        b_zero;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] a_raw;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    // Multiply: {partial product, remaining multiplier bits}, shifted right.
    // Divide:   {partial remainder, remaining dividend/quotient bits}, shifted left.
    logic [63:0] work;
    logic        busy_q;
    logic        done_q;
    logic        div_zero_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    // Operand magnitudes at start. Only MULT and DIV (op[0] = 0) are signed.
    logic        in_signed;
    logic        in_neg_a;
    logic        in_neg_b;
    logic [31:0] in_abs_a;
    logic [31:0] in_abs_b;

    assign in_signed = ~bus.op[0];
    assign in_neg_a  = in_signed & bus.a[31];
    assign in_neg_b  = in_signed & bus.b[31];
    assign in_abs_a  = in_neg_a ? (~bus.a + 32'd1) : bus.a;
    assign in_abs_b  = in_neg_b ? (~bus.b + 32'd1) : bus.b;

    // One shift-add multiply step: add the multiplicand when the current
    // multiplier bit is set, then shift the whole accumulator right.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    assign mul_sum  = {1'b0, work[63:32]} + (work[0] ? {1'b0, mag_a} : 33'd0);
    assign mul_next = {mul_sum, work[31:1]};

    // One restoring divide step. The 33-bit shifted remainder is compared
    // against the divisor. Bit 33 of the trial subtraction is the borrow.
    logic [32:0] rem_shift;
    logic [33:0] trial;
    logic [63:0] div_next;

    assign rem_shift = {work[63:32], work[31]};
    assign trial     = {1'b0, rem_shift} - {2'b00, mag_b};
    assign div_next  = trial[33] ? {rem_shift[31:0], work[30:0], 1'b0}
                                 : {trial[31:0],     work[30:0], 1'b1};

    // Sign-corrected results, consumed in FIX.
    logic        neg_prod;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    assign neg_prod = sign_a ^ sign_b;
    assign prod     = neg_prod ? (~work + 64'd1) : work;
    assign quo      = neg_prod ? (~work[31:0] + 32'd1) : work[31:0];
    assign rem      = sign_a ? (~work[63:32] + 32'd1) : work[63:32];

    // Select the value written to HI/LO at the end of FIX.
    always_comb begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        if (is_div) begin
            if (b_zero) begin
                res_hi = a_raw;
                res_lo = 32'hFFFF_FFFF;
            end else begin
                res_hi = rem;
                res_lo = quo;
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic: start in IDLE, 32 RUN iterations, one FIX cycle.
    always_comb begin
        // NOTE: default first, so no path leaves state_next unassigned and no latch is inferred.
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (cnt == 5'd31) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, iterate, commit results, and handle MT writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= 5'd0;
            is_div     <= 1'b0;
            b_zero     <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            a_raw      <= 32'd0;
            mag_a      <= 32'd0;
            mag_b      <= 32'd0;
            work       <= 64'd0;
            hi_q       <= 32'd0;
            lo_q       <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        cnt    <= 5'd0;
                        is_div <= bus.op[1];
                        b_zero <= (bus.b == 32'd0);
                        sign_a <= in_neg_a;
                        sign_b <= in_neg_b;
                        a_raw  <= bus.a;
                        mag_a  <= in_abs_a;
                        mag_b  <= in_abs_b;
                        // Multiply seeds the accumulator with the multiplier.
                        // Divide seeds it with the dividend.
                        work   <= {32'd0, bus.op[1] ? in_abs_a : in_abs_b};
                    end else begin
                        if (bus.mthi) hi_q <= bus.mt_data;
                        if (bus.mtlo) lo_q <= bus.mt_data;
                    end
                end
                RUN: begin
                    cnt  <= cnt + 5'd1;
                    work <= is_div ? div_next : mul_next;
                end
                FIX: begin
                    hi_q <= res_hi;
                    lo_q <= res_lo;
                end
                default: ;
            endcase
        end
    end

    // Registered handshake outputs. done and div_zero pulse on the FIX->IDLE edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            busy_q     <= (state_next != IDLE);
            done_q     <= (state == FIX);
            div_zero_q <= (state == FIX) && is_div && b_zero;
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit for the MIPS core, sitting directly downstream of the register file. It consumes the two register-file read operands (rs on `a`, rt on `b`) for MULT/MULTU/DIV/DIVU and holds the results in internal HI/LO registers. HI/LO are read back by MFHI/MFLO and written directly by MTHI/MTLO. A busy/done handshake lets the pipeline control stall dependent instructions.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin the operation selected by `op`; sampled only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `a`  in  32  rs operand (multiplicand / dividend).
- `b`  in  32  rt operand (multiplier / divisor).
- `mthi`  in  1  write `mt_data` into HI.
- `mtlo`  in  1  write `mt_data` into LO.
- `mt_data`  in  32  MTHI/MTLO data.
- `busy`  out  1  operation in progress; start, mthi and mtlo are ignored.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `div_zero`  out  1  one-cycle pulse together with `done` when a DIV/DIVU had `b == 0`.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- FSM states: IDLE, RUN, FIX.
  - IDLE: `start`=1 → RUN. Latch `a`, `b` and `op`, and record the operand signs. Clear the 5-bit iteration counter. Signed ops (MULT, DIV) take two's-complement magnitudes.
  - RUN: exactly 32 iterations, one per edge. Counter 31 → FIX.
    - Multiply: shift-add into a 64-bit accumulator.
    - Divide: restoring, one quotient bit per edge. The remainder register is 33 bits wide.
  - FIX: apply the sign correction, write HI/LO, pulse `done` → IDLE.
- Result rules:
  - MULT/MULTU: {HI,LO} = the 64-bit product. MULT negates the product when the operand signs differ.
  - DIV/DIVU: LO = quotient, HI = remainder.
  - DIV truncates toward zero. The remainder takes the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF (DIV) gives LO=0x80000000, HI=0.
- Divide by zero (DIV or DIVU with `b`=0): same latency as a normal divide. Result is LO=0xFFFFFFFF, HI=`a` (raw latched value, no sign fix). `div_zero` pulses with `done`.
- MTHI/MTLO:
  - In IDLE with `start`=0, HI/LO take `mt_data` at the next edge.
  - `mthi` and `mtlo` may both be set in the same cycle; both registers are written.
  - Ignored while `busy`.
  - If `start`=1 in the same cycle, `start` wins and mthi/mtlo are dropped.
- Operands are latched, so `a`, `b` and `op` may change freely after the start cycle.
- `hi`/`lo` hold their previous values throughout RUN and FIX. They change only on the FIX→IDLE edge or on an accepted MT write.

## Timing
- Reset (`rst`=0, asynchronous): state IDLE, counter 0, `hi`=`lo`=0, `busy`=0, `done`=0, `div_zero`=0. Reset asserted mid-operation aborts it; no partial result reaches HI/LO.
- Cycle numbering: `start` is high in cycle 0 and sampled at edge 1.
  - `busy`=1 in cycles 1–33 (32 RUN cycles plus 1 FIX cycle).
  - `done`=1 and `busy`=0 in cycle 34; new HI/LO are visible in cycle 34.
- Total latency: 34 cycles from the start cycle to `done`, for every op including divide by zero.
- Back-to-back: the `done` cycle is IDLE, so a `start` in cycle 34 is accepted. That gives one operation per 34 cycles.
- `busy` is a registered output derived from the state (state ≠ IDLE). `done` and `div_zero` are registered, never combinational from inputs.
- `start` held high continuously restarts the unit in every `done` cycle with the operands present at that time.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001; `done` exactly in cycle 34; `busy` high in cycles 1–33.
- MULT −3 (0xFFFFFFFD) × 7 → HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0.
- Division cases:
  - DIV −7 / 2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - DIVU 100 / 7 → LO=14, HI=2.
  - DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- DIVU 0x1234 / 0 → `done`+`div_zero` pulse in cycle 34; LO=0xFFFFFFFF, HI=0x1234.
- MTHI 0xAAAA5555 in IDLE → `hi` updates next cycle. MTLO 0x1 while busy → `lo` unchanged. `start`+`mtlo` together → op runs, MT dropped. Operands changed in cycle 1 do not affect the result.
- Reset behaviour:
  - Drive `rst`=0 at cycle 15 of a MULT → `busy`/`done`/`hi`/`lo` go to 0 immediately, with no clock edge needed.
  - After release, a new MULTU 3×5 gives LO=15, HI=0.
  - A `start` issued in a `done` cycle is accepted back-to-back.
